rtc_write_sequencer: RTL and testbench
======================================

Name: rtc_write_sequencer

Overview:
- Downstream stage of the time/date/timer data-entry block: consumes its nine 8-bit BCD field registers and writes them into the external RTC chip over its multiplexed address/data bus.
- On a one-cycle `start` request it snapshots all fields, then runs one address-phase/data-phase bus write per register, in fixed order.
- Reports `busy` during the sequence and pulses `done` at the end.
- Sits between the data-entry block and the top-level RTC pads. Bus tristating is done at top level using `bus_oe`.

Parameters:
- T_STROBE, 4: number of clk cycles `wr_n` is held low in each address or data phase (legal range 1..15).
- ADDR_BASE_C, 8'h21: RTC address of seconds. The clock/date block occupies ADDR_BASE_C..ADDR_BASE_C+5.
- ADDR_BASE_T, 8'h41: RTC address of timer seconds. The timer block occupies ADDR_BASE_T..ADDR_BASE_T+2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle write request
- seg_C  in  8  clock seconds, BCD
- min_C  in  8  clock minutes, BCD
- hora_C  in  8  clock hours, BCD
- dia  in  8  day, BCD
- mes  in  8  month, BCD
- ano  in  8  year, BCD
- seg_T  in  8  timer seconds, BCD
- min_T  in  8  timer minutes, BCD
- hora_T  in  8  timer hours, BCD
- dato_out  out  8  value driven on the RTC AD bus
- bus_oe  out  1  1 = top level drives `dato_out` onto the pads
- cs_n  out  1  chip select, active low
- a_d  out  1  0 = address phase, 1 = data phase
- wr_n  out  1  write strobe, active low
- rd_n  out  1  read strobe; held at 1 (this block never reads)
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset values: `dato_out`=0, `bus_oe`=0, `cs_n`=1, `a_d`=0, `wr_n`=1, `rd_n`=1, `busy`=0, `done`=0. State = IDLE, register index = 0, strobe counter = 0.
- A reset asserted mid-sequence aborts at the next edge and forces the reset values. No partial completion, no `done`.
- IDLE: when `start`=1, latch all nine inputs into shadow registers, set index=0 and go to A_SETUP. Input changes after this edge do not affect the sequence.
- `start` is ignored while `busy`=1, and also in the `done` cycle.
- Per register the states run in this order: A_SETUP (1 cycle) -> A_STROBE (T_STROBE cycles) -> A_HOLD (1) -> A_GAP (1) -> D_SETUP (1) -> D_STROBE (T_STROBE) -> D_HOLD (1) -> D_GAP (1).
- Each register write therefore takes 2*T_STROBE+6 cycles (14 at the defaults).
- Outputs in the address states:
  - A_SETUP, A_STROBE, A_HOLD: `cs_n`=0, `a_d`=0, `bus_oe`=1, `dato_out`=address.
  - `wr_n`=0 only in A_STROBE.
- Outputs in the data states:
  - D_SETUP, D_STROBE, D_HOLD: `cs_n`=0, `a_d`=1, `bus_oe`=1, `dato_out`=shadow data.
  - `wr_n`=0 only in D_STROBE.
- Outputs in the gap states (A_GAP, D_GAP): `cs_n`=1, `wr_n`=1, `bus_oe`=0, `dato_out` holds its last value.
- Write order, with index 0..8:
  - 0 seg_C @ADDR_BASE_C
  - 1 min_C @+1
  - 2 hora_C @+2
  - 3 dia @+3
  - 4 mes @+4
  - 5 ano @+5
  - 6 seg_T @ADDR_BASE_T
  - 7 min_T @+1
  - 8 hora_T @+2
- Address arithmetic is an 8-bit add with no carry out.
- After D_GAP:
  - If index is the last one, go to DONE.
  - Otherwise increment index and go to A_SETUP.
- DONE: one cycle with `done`=1 and `busy`=0, then IDLE.
- Signal invariants:
  - `wr_n`=0 is never asserted while `cs_n`=1.
  - `a_d` never changes while `wr_n`=0.
  - `dato_out` never changes while `cs_n`=0 within a phase.
- Data is passed through unmodified; this block performs no BCD range checks.

Optional Feature:
- Macro: RTC_TIMER_WRITE_EN.
- Defined: all 9 registers are written. Total sequence is 9*(2*T_STROBE+6) cycles, i.e. 126 at the defaults.
- Undefined:
  - Only indices 0..5 (clock/date) are written, and D_GAP of index 5 goes to DONE (84 cycles at the defaults).
  - The timer inputs are still ports but are not latched.

Test Plan:
- Reset, then `start` with seg_C=8'h45, min_C=8'h30, hora_C=8'h12, dia=8'h22, mes=8'h09, ano=8'h16, seg_T=8'h10, min_T=8'h05, hora_T=8'h01 -> bus monitor records pairs (21,45) (22,30) (23,12) (24,22) (25,09) (26,16) (41,10) (42,05) (43,01). `done` arrives 127 cycles after `start`, and `busy` is high for exactly 126 cycles.
- Change every input on the cycle after `start` -> written data still equals the values latched at `start`.
- Pulse `start` again at cycle 40 of the sequence -> ignored: exactly 9 writes occur and a single `done`.
- Assert `reset` during the 3rd register's D_STROBE -> the next cycle shows `cs_n`=1, `wr_n`=1, `bus_oe`=0, `busy`=0, and no `done` follows. A later `start` performs the full 9-write sequence.
- Protocol checker running over all scenarios -> `rd_n` is always 1; `wr_n` low lasts exactly T_STROBE cycles with `cs_n`=0; `a_d` and `dato_out` are stable across every strobe.
- Build without RTC_TIMER_WRITE_EN, run the first scenario -> only the first 6 pairs are written, `done` arrives 85 cycles after `start`, and addresses 0x41..0x43 never appear.

Source files
------------

// File: rtl/rtc_write_sequencer.sv
// Writes the nine BCD time/date/timer fields to the external RTC over its multiplexed AD bus.
// Optional macro RTC_TIMER_WRITE_EN: when defined the three timer fields are also written.
module rtc_write_sequencer #(
   parameter int unsigned T_STROBE    = 4,
   parameter logic [7:0]  ADDR_BASE_C = 8'h21,
   parameter logic [7:0]  ADDR_BASE_T = 8'h41
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] seg_C,
   input  logic [7:0] min_C,
   input  logic [7:0] hora_C,
   input  logic [7:0] dia,
   input  logic [7:0] mes,
   input  logic [7:0] ano,
   input  logic [7:0] seg_T,
   input  logic [7:0] min_T,
   input  logic [7:0] hora_T,
   output logic [7:0] dato_out,
   output logic       bus_oe,
   output logic       cs_n,
   output logic       a_d,
   output logic       wr_n,
   output logic       rd_n,
   output logic       busy,
   output logic       done
);

`ifdef RTC_TIMER_WRITE_EN
   localparam int unsigned N_REGS = 9;
`else
   localparam int unsigned N_REGS = 6;
`endif
   localparam logic [3:0] LAST_IDX    = 4'(N_REGS - 1);
   localparam logic [3:0] STROBE_LAST = 4'(T_STROBE - 1);

   typedef enum logic [3:0] {
      IDLE, A_SETUP, A_STROBE, A_HOLD, A_GAP,
      D_SETUP, D_STROBE, D_HOLD, D_GAP, DONE
   } state_t;

   state_t                  state, state_nxt;
   logic [3:0]              idx, idx_nxt;
   logic [3:0]              cnt, cnt_nxt;
   logic [7:0]              dato_q;
   logic [7:0]              cur_addr;
   logic                    load, shift;
   logic [N_REGS*8-1:0]     shadow_q;
   logic [N_REGS*8-1:0]     fields;

`ifdef RTC_TIMER_WRITE_EN
   assign fields = {hora_T, min_T, seg_T, ano, mes, dia, hora_C, min_C, seg_C};
`else
   logic unused_timer;
   assign unused_timer = ^{hora_T, min_T, seg_T};
   assign fields = {ano, mes, dia, hora_C, min_C, seg_C};
`endif

   // Field 0 sits in the low byte; the snapshot shifts down one byte per completed register.
   always_comb begin
      if (idx < 4'd6) cur_addr = ADDR_BASE_C + {4'b0, idx};
      else            cur_addr = ADDR_BASE_T + {4'b0, idx - 4'd6};
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         cnt    <= '0;
         dato_q <= '0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
         dato_q <= dato_out;
      end
   end

   // NOTE: the snapshot is pure datapath, always loaded before use, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load)       shadow_q <= fields;
      else if (shift) shadow_q <= shadow_q >> 8;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      load      = 1'b0;
      shift     = 1'b0;
      dato_out  = dato_q;
      bus_oe    = 1'b0;
      cs_n      = 1'b1;
      a_d       = 1'b0;
      wr_n      = 1'b1;
      rd_n      = 1'b1;
      busy      = 1'b1;
      done      = 1'b0;

      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               load      = 1'b1;
               idx_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = A_SETUP;
            end
         end
         A_SETUP, A_STROBE, A_HOLD: begin
            cs_n     = 1'b0;
            bus_oe   = 1'b1;
            dato_out = cur_addr;
            if (state == A_SETUP) begin
               state_nxt = A_STROBE;
            end else if (state == A_STROBE) begin
               wr_n = 1'b0;
               if (cnt == STROBE_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = A_HOLD;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end else begin
               state_nxt = A_GAP;
            end
         end
         A_GAP: state_nxt = D_SETUP;
         D_SETUP, D_STROBE, D_HOLD: begin
            cs_n     = 1'b0;
            a_d      = 1'b1;
            bus_oe   = 1'b1;
            dato_out = shadow_q[7:0];
            if (state == D_SETUP) begin
               state_nxt = D_STROBE;
            end else if (state == D_STROBE) begin
               wr_n = 1'b0;
               if (cnt == STROBE_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = D_HOLD;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end else begin
               state_nxt = D_GAP;
            end
         end
         D_GAP: begin
            shift = 1'b1;
            if (idx == LAST_IDX) begin
               state_nxt = DONE;
            end else begin
               idx_nxt   = idx + 4'd1;
               state_nxt = A_SETUP;
            end
         end
         DONE: begin
            busy      = 1'b0;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Scoreboard bench for rtc_write_sequencer: bus monitor, protocol checker, timing and abort scenarios.
module tb_rtc_write_sequencer;

   localparam int TS = 4;
`ifdef RTC_TIMER_WRITE_EN
   localparam int NWR = 9;
`else
   localparam int NWR = 6;
`endif
   localparam int SEQ = NWR * (2 * TS + 6);

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] seg_C = '0, min_C = '0, hora_C = '0, dia = '0, mes = '0, ano = '0;
   logic [7:0] seg_T = '0, min_T = '0, hora_T = '0;
   logic [7:0] dato_out;
   logic       bus_oe, cs_n, a_d, wr_n, rd_n, busy, done;

   rtc_write_sequencer #(.T_STROBE(TS), .ADDR_BASE_C(8'h21), .ADDR_BASE_T(8'h41)) dut (
      .clk(clk), .reset(reset), .start(start),
      .seg_C(seg_C), .min_C(min_C), .hora_C(hora_C), .dia(dia), .mes(mes), .ano(ano),
      .seg_T(seg_T), .min_T(min_T), .hora_T(hora_T),
      .dato_out(dato_out), .bus_oe(bus_oe), .cs_n(cs_n), .a_d(a_d),
      .wr_n(wr_n), .rd_n(rd_n), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  done_count = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_addr(input int i);
      logic [7:0] a;
      if (i < 6) a = 8'h21 + 8'(i);
      else       a = 8'h41 + 8'(i - 6);
      return a;
   endfunction

   task automatic apply(input logic [71:0] v);
      seg_C = v[7:0];   min_C = v[15:8];  hora_C = v[23:16];
      dia   = v[31:24]; mes   = v[39:32]; ano    = v[47:40];
      seg_T = v[55:48]; min_T = v[63:56]; hora_T = v[71:64];
   endtask

   task automatic push_expected(input logic [71:0] v);
      wr_t w;
      for (int i = 0; i < NWR; i++) begin
         w.addr = exp_addr(i);
         w.data = v[8*i +: 8];
         sb.push_back(w);
      end
   endtask

   // Bus monitor and protocol checker, sampled on the falling edge.
   logic       prev_wr_n = 1'b1, prev_cs_n = 1'b1, prev_a_d = 1'b0;
   logic [7:0] prev_dato = '0, cap_addr = '0;
   logic       have_addr = 1'b0;
   int         strobe_len = 0;

   always @(negedge clk) begin
      wr_t w;
      if (done) done_count++;
      if (reset) begin
         prev_wr_n  = 1'b1;
         prev_cs_n  = 1'b1;
         strobe_len = 0;
         have_addr  = 1'b0;
      end else begin
         check("rd_n_high", rd_n, 1);
         check("oe_vs_cs", bus_oe, !cs_n);
         if (!cs_n && !prev_cs_n && a_d == prev_a_d)
            check("dato_stable", dato_out, prev_dato);
         if (!wr_n) begin
            check("wr_with_cs", cs_n, 0);
            if (!prev_wr_n) check("ad_stable", a_d, prev_a_d);
            strobe_len++;
         end else if (!prev_wr_n) begin
            check("strobe_len", strobe_len, TS);
            strobe_len = 0;
            if (!prev_a_d) begin
               cap_addr  = prev_dato;
               have_addr = 1'b1;
            end else begin
               check("addr_before_data", have_addr, 1);
               have_addr = 1'b0;
               check("sb_nonempty", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  w = sb.pop_front();
                  check("wr_addr", cap_addr, w.addr);
                  check("wr_data", prev_dato, w.data);
               end
            end
         end
         prev_wr_n = wr_n;
         prev_cs_n = cs_n;
         prev_a_d  = a_d;
         prev_dato = dato_out;
      end
   end

   // Drive one write request and measure done latency and busy length (cycle 0 = start cycle).
   task automatic run_seq(input logic [71:0] v, input bit chg, input int repulse);
      int cnt, busy_cnt, done_at, dones0;
      logic [71:0] alt;
      push_expected(v);
      @(posedge clk); #1;
      apply(v);
      start  = 1'b1;
      dones0 = done_count;
      cnt = 0; busy_cnt = 0; done_at = 0;
      while (done_at == 0 && cnt < 400) begin
         @(posedge clk); #1;
         cnt++;
         if (cnt == 1) begin
            start = 1'b0;
            if (chg) begin
               alt = ~v;
               apply(alt);
            end
         end
         if (repulse != 0 && cnt == repulse)     start = 1'b1;
         if (repulse != 0 && cnt == repulse + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) done_at = cnt;
      end
      check("done_latency", done_at, SEQ + 1);
      check("busy_cycles", busy_cnt, SEQ);
      repeat (20) @(posedge clk);
      #1;
      check("done_pulses", done_count - dones0, 1);
      check("sb_drained", sb.size(), 0);
   endtask

   initial begin
      logic [71:0] r;
      int          cnt, dones0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_dato", dato_out, 0);
      check("rst_oe", bus_oe, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_a_d", a_d, 0);
      check("rst_wr_n", wr_n, 1);
      check("rst_rd_n", rd_n, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // Reference transaction.
      run_seq(72'h01_05_10_16_09_22_12_30_45, 1'b0, 0);

      // Inputs change right after start; snapshot must win.
      r = {$urandom(), $urandom(), 8'($urandom())};
      run_seq(r, 1'b1, 0);

      // Second start during the sequence is ignored.
      r = {$urandom(), $urandom(), 8'($urandom())};
      run_seq(r, 1'b0, 40);

      // Reset during the third register's data strobe aborts the sequence.
      r = {$urandom(), $urandom(), 8'($urandom())};
      push_expected(r);
      @(posedge clk); #1;
      apply(r);
      start  = 1'b1;
      dones0 = done_count;
      for (cnt = 1; cnt <= 39; cnt++) begin
         @(posedge clk); #1;
         if (cnt == 1)  start = 1'b0;
         if (cnt == 38) begin
            check("pre_abort_wr_n", wr_n, 0);
            check("pre_abort_a_d", a_d, 1);
            reset = 1'b1;
         end
         if (cnt == 39) begin
            check("abort_cs_n", cs_n, 1);
            check("abort_wr_n", wr_n, 1);
            check("abort_oe", bus_oe, 0);
            check("abort_busy", busy, 0);
            reset = 1'b0;
            sb.delete();
         end
      end
      repeat (200) @(posedge clk);
      #1;
      check("abort_no_done", done_count - dones0, 0);
      check("abort_idle", busy, 0);

      // Full sequence after the abort.
      r = {$urandom(), $urandom(), 8'($urandom())};
      run_seq(r, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
